// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient} and holds it until the request is withdrawn.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic        op1_neg;
  logic        quo_neg;

  logic [31:0] abs_op1;
  logic [31:0] abs_op2;
  logic [32:0] diff;
  logic [31:0] quo;
  logic [31:0] rem;

  // Magnitudes are only taken for signed operations with a negative operand.
  assign abs_op1 = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_op2 = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
  assign quo  = quo_neg ? (~dividend[31:0] + 32'd1) : dividend[31:0];
  assign rem  = op1_neg ? (~dividend[64:33] + 32'd1) : dividend[64:33];

  assign busy_o = (state == ZERO) || (state == ON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      dividend <= 65'd0;
      divisor  <= 32'd0;
      op1_neg  <= 1'b0;
      quo_neg  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
          if (start_i) begin
            if (opdata2_i == 32'd0) begin
              state <= ZERO;
            end else begin
              state    <= ON;
              cnt      <= 6'd0;
              dividend <= {32'd0, abs_op1, 1'b0};
              divisor  <= abs_op2;
              op1_neg  <= signed_i & opdata1_i[31];
              quo_neg  <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            end
          end
        end
        ZERO: begin
          // Division by zero is defined to return all zeros.
          state    <= END;
          result_o <= 64'd0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (cnt != 6'd32) begin
            if (diff[32]) begin
              dividend <= {dividend[63:0], 1'b0};
            end else begin
              dividend <= {diff[31:0], dividend[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            state    <= END;
            cnt      <= 6'd0;
            result_o <= {rem, quo};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= IDLE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized checks of div_seq: latency, signed/unsigned results,
// divide-by-zero, annul and asynchronous reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic        na;
    logic        nb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Called #1 after a rising edge with the DUT idle. Returns the result, the
  // number of edges from the start cycle to ready, and the outputs one edge
  // after start_i drops.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat,
                        output logic rdy_after, output logic [63:0] res_after);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    start_i = 1'b0;
    @(posedge clk); #1;
    rdy_after = ready_o;
    res_after = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b result=%h, required 0/0/0", ready_o, busy_o, result_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: ready=%b busy=%b result=%h", ready_o, busy_o, result_o);
  endtask

  task automatic test_unsigned();
    logic [63:0] res, res_after;
    int lat;
    logic rdy_after;
    do_div(32'd100, 32'd7, 1'b0, res, lat, rdy_after, res_after);
    $display("unsigned 100/7: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL unsigned_100_7: result=%h required=%h", res, {32'd2, 32'd14});
    end
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL unsigned_latency: got %0d required 34", lat);
    end
    checks++;
    if (rdy_after !== 1'b0 || res_after !== 64'd0) begin
      errors++;
      $display("FAIL ready_drop: ready=%b result=%h required 0/0", rdy_after, res_after);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res, res_after;
    int lat;
    logic rdy_after;
    do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, res, lat, rdy_after, res_after);
    $display("signed -7/2: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL signed_m7_2: result=%h required=%h", res, 64'hFFFF_FFFF_FFFF_FFFD);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, rdy_after, res_after);
    $display("signed overflow: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL signed_overflow: result=%h required=%h", res, 64'h0000_0000_8000_0000);
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, res, lat, rdy_after, res_after);
    $display("signed 7/-2: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 64'h0000_0001_FFFF_FFFD) begin
      errors++;
      $display("FAIL signed_7_m2: result=%h required=%h", res, 64'h0000_0001_FFFF_FFFD);
    end
  endtask

  task automatic test_div_zero();
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL divzero_busy: busy=%b ready=%b required 1/0", busy_o, ready_o);
    end
    @(posedge clk); #1;
    $display("div by zero 5/0: ready=%b busy=%b result=%h", ready_o, busy_o, result_o);
    checks++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL divzero_result: ready=%b busy=%b result=%h required 1/0/0", ready_o, busy_o, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL divzero_drop: ready=%b required 0", ready_o);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res, res_after;
    int lat;
    logic rdy_after;
    int ready_seen;
    // annul together with start in IDLE: nothing starts
    start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle: busy=%b required 0", busy_o);
    end
    annul_i = 1'b0;
    repeat (11) @(posedge clk); // E0 plus ten iterations
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL annul_pre_busy: busy=%b required 1", busy_o);
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL annul_on: busy=%b ready=%b result=%h required 0/0/0", busy_o, ready_o, result_o);
    end
    ready_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL annul_no_ready: ready cycles=%0d required 0", ready_seen);
    end
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, res, lat, rdy_after, res_after);
    $display("after annul 0xFFFFFFFF/1: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== 64'h0000_0000_FFFF_FFFF || lat !== 34) begin
      errors++;
      $display("FAIL after_annul: result=%h latency=%0d required %h/34", res, lat, 64'h0000_0000_FFFF_FFFF);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] res, res_after;
    int lat;
    logic rdy_after;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_on: busy=%b ready=%b result=%h required 0/0/0", busy_o, ready_o, result_o);
    end
    #2;
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    // reset while a result is being held
    start_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd4;
    repeat (36) @(posedge clk);
    #3;
    checks++;
    if (ready_o !== 1'b1 || result_o !== {32'd1, 32'd2}) begin
      errors++;
      $display("FAIL held_result: ready=%b result=%h required 1/%h", ready_o, result_o, {32'd1, 32'd2});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_end: ready=%b result=%h required 0/0", ready_o, result_o);
    end
    #2;
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    do_div(32'd1000, 32'd3, 1'b0, res, lat, rdy_after, res_after);
    $display("after reset 1000/3: result=%h latency=%0d", res, lat);
    checks++;
    if (res !== {32'd1, 32'd333} || lat !== 34) begin
      errors++;
      $display("FAIL after_reset: result=%h latency=%0d required %h/34", res, lat, {32'd1, 32'd333});
    end
  endtask

  task automatic test_random();
    logic [63:0] res, res_after, exp;
    int lat;
    logic rdy_after;
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i < 10) ? $urandom : ($urandom % 32'd50) - 32'd25;
      if (b == 32'd0) b = 32'd1;
      s = i[0];
      exp = ref_div(a, b, s);
      do_div(a, b, s, res, lat, rdy_after, res_after);
      $display("random %0d: %s %h/%h result=%h latency=%0d", i, s ? "div " : "divu", a, b, res, lat);
      checks++;
      if (res !== exp || lat !== 34) begin
        errors++;
        $display("FAIL random_%0d: result=%h latency=%0d required %h/34", i, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
